// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-to-transmit loopback FIFO.
// State encodings for the receive and transmit handshake FSMs.
package uart_pkg;

  localparam int unsigned UartDataWidth = 8;

  typedef enum logic {
    RIdle,
    RAck
  } rx_state_e;

  typedef enum logic [1:0] {
    TIdle,
    TLaunch,
    TWait
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the loopback FIFO: one write port, one registered read port.
// Storage is not reset; only the read-data register is.
module uart_fifo_mem #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only updates on a pop, so the output holds between launches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_loopback_fifo.sv
// Byte FIFO between a UART receiver and transmitter, owning both handshakes.
// Define UART_FIFO_STATUS_EN to expose count_o and the sticky overflow_o flag.
module uart_loopback_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UartDataWidth,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_clear_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_write_o,
`ifdef UART_FIFO_STATUS_EN
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
`endif
  input  logic                  tx_busy_i
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DepthCnt = Depth[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CntOne   = 1;
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = 1;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  clear_q, clear_d;
  logic                  write_q, write_d;
  logic                  full, empty;
  logic                  push, pop;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // Receive side: one push per received byte, acknowledge held until ready drops.
  always_comb begin
    rx_state_d = rx_state_q;
    clear_d    = clear_q;
    push       = 1'b0;
    case (rx_state_q)
      RIdle: begin
        if (rx_ready_i) begin
          // A same-cycle pop frees a slot, so a full FIFO still accepts.
          push       = ~full | pop;
          clear_d    = 1'b1;
          rx_state_d = RAck;
        end
      end
      RAck: begin
        if (!rx_ready_i) begin
          clear_d    = 1'b0;
          rx_state_d = RIdle;
        end
      end
      default: rx_state_d = RIdle;
    endcase
  end

  // Transmit side: pop and launch when idle, hold write until busy acknowledges it.
  always_comb begin
    tx_state_d = tx_state_q;
    write_d    = write_q;
    pop        = 1'b0;
    case (tx_state_q)
      TIdle: begin
        if (!empty && !tx_busy_i) begin
          pop        = 1'b1;
          write_d    = 1'b1;
          tx_state_d = TLaunch;
        end
      end
      TLaunch: begin
        if (tx_busy_i) begin
          write_d    = 1'b0;
          tx_state_d = TWait;
        end
      end
      TWait: begin
        if (!tx_busy_i) begin
          tx_state_d = TIdle;
        end
      end
      default: tx_state_d = TIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_state_q <= RIdle;
      tx_state_q <= TIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      clear_q    <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      clear_q    <= clear_d;
      write_q    <= write_d;
    end
  end

`ifdef UART_FIFO_STATUS_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (rx_state_q == RIdle && rx_ready_i && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
`endif

  uart_fifo_mem #(
    .DataWidth(DATA_WIDTH),
    .AddrWidth(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clock_i),
    .rst_i  (reset_i),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(rx_data_i),
    .re_i   (pop),
    .raddr_i(rd_ptr_q),
    .rdata_o(tx_data_o)
  );

  assign rx_clear_ready_o = clear_q;
  assign tx_write_o       = write_q;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Scoreboard bench for uart_loopback_fifo: receiver/transmitter models plus a launch monitor.
module tb_uart_loopback_fifo;

  localparam int AW = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_clear_ready;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_busy;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
`ifdef UART_FIFO_STATUS_EN
  logic [AW:0] count;
  logic        overflow;
`endif

  assign tx_busy = force_busy | model_busy;

  uart_loopback_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .rx_data_i       (rx_data),
    .rx_ready_i      (rx_ready),
    .rx_clear_ready_o(rx_clear_ready),
    .tx_data_o       (tx_data),
    .tx_write_o      (tx_write),
`ifdef UART_FIFO_STATUS_EN
    .count_o         (count),
    .overflow_o      (overflow),
`endif
    .tx_busy_i       (tx_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass = 0;
  int n_launch = 0;
  int launch_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Launch monitor: pops the scoreboard on each tx_write rise.
  initial begin : monitor
    logic prev_write;
    logic [7:0] cur_byte;
    prev_write = 1'b0;
    cur_byte = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_write = 1'b0;
      end else begin
        if (tx_write && !prev_write) begin
          launch_cyc = cyc;
          n_launch++;
          cur_byte = tx_data;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_launch: got %0h expected no launch", tx_data);
          end else begin
            chk("launch_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
          end
        end else if (tx_write && prev_write) begin
          chk("launch_hold", {24'h0, tx_data}, {24'h0, cur_byte});
        end else if (!tx_write && prev_write) begin
          chk("write_drop_on_busy", {31'h0, tx_busy}, 32'h1);
        end
        prev_write = tx_write;
      end
    end
  end

  // Transmitter model: busy rises one cycle after a launch and lasts two cycles.
  initial begin : tx_model
    forever begin
      @(negedge clock);
      if (tx_write && !model_busy) begin
        @(posedge clock); #1;
        model_busy = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_clear(input logic lvl, input string nm);
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (rx_clear_ready == lvl) break;
    end
    chk(nm, {31'h0, rx_clear_ready}, {31'h0, lvl});
  endtask

  // Receiver model: drops ready two cycles after seeing the acknowledge.
  task automatic send_byte(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    rx_data = b;
    rx_ready = 1'b1;
    wait_clear(1'b1, "ack_rise");
    repeat (2) @(posedge clock);
    #1;
    rx_ready = 1'b0;
    wait_clear(1'b0, "ack_fall");
    @(posedge clock); #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 0 && !tx_busy && !tx_write) break;
    end
    chk(nm, exp_q.size(), 0);
    repeat (8) @(posedge clock);
    #1;
  endtask

  initial begin : stim
    int c0;
    int n0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_tx_write", {31'h0, tx_write}, 32'h0);
    chk("reset_clear", {31'h0, rx_clear_ready}, 32'h0);
    chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
`ifdef UART_FIFO_STATUS_EN
    chk("reset_count", {27'h0, count}, 32'h0);
    chk("reset_overflow", {31'h0, overflow}, 32'h0);
`endif
    repeat (2) @(posedge clock);
    #1;

    // Single byte with latency measurement.
    n0 = n_launch;
    c0 = cyc;
    send_byte(8'hA5, 1'b1);
    wait_drain("single_drain");
    chk("single_latency", launch_cyc - c0, 2);
    chk("single_launches", n_launch - n0, 1);
`ifdef UART_FIFO_STATUS_EN
    chk("single_count", {27'h0, count}, 32'h0);
`endif

    // Burst while the transmitter is busy.
    n0 = n_launch;
    force_busy = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
`ifdef UART_FIFO_STATUS_EN
    chk("burst_count", {27'h0, count}, 32'h5);
`endif
    force_busy = 1'b0;
    wait_drain("burst_drain");
    chk("burst_launches", n_launch - n0, 5);

    // Fill to 16 and overflow with a 17th byte.
    n0 = n_launch;
    force_busy = 1'b1;
    for (int i = 1; i <= 17; i++) send_byte(8'(8'h10 + i), i <= 16);
`ifdef UART_FIFO_STATUS_EN
    chk("full_count", {27'h0, count}, 32'h10);
    chk("full_overflow", {31'h0, overflow}, 32'h1);
`endif
    force_busy = 1'b0;
    wait_drain("full_drain");
    chk("full_launches", n_launch - n0, 16);
`ifdef UART_FIFO_STATUS_EN
    chk("overflow_sticky", {31'h0, overflow}, 32'h1);
`endif

    // Push and pop in the same cycle while full.
    n0 = n_launch;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b1);
    exp_q.push_back(8'h77);
    rx_data = 8'h77;
    rx_ready = 1'b1;
    force_busy = 1'b0;
    @(posedge clock); #1;
`ifdef UART_FIFO_STATUS_EN
    chk("simul_count", {27'h0, count}, 32'h10);
`endif
    chk("simul_ack", {31'h0, rx_clear_ready}, 32'h1);
    repeat (2) @(posedge clock);
    #1;
    rx_ready = 1'b0;
    wait_clear(1'b0, "simul_ack_fall");
    wait_drain("simul_drain");
    chk("simul_launches", n_launch - n0, 17);

    // Continuous traffic wrapping the pointers.
    n0 = n_launch;
    for (int i = 0; i < 40; i++) send_byte(8'(i * 7 + 3), 1'b1);
    wait_drain("wrap_drain");
    chk("wrap_launches", n_launch - n0, 40);

    // Reset while a launch is pending and three bytes remain queued.
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 1'b1);
    force_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (tx_write) break;
    end
    chk("pre_reset_write", {31'h0, tx_write}, 32'h1);
`ifdef UART_FIFO_STATUS_EN
    chk("pre_reset_count", {27'h0, count}, 32'h3);
`endif
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midreset_tx_write", {31'h0, tx_write}, 32'h0);
    chk("midreset_tx_data", {24'h0, tx_data}, 32'h0);
`ifdef UART_FIFO_STATUS_EN
    chk("midreset_count", {27'h0, count}, 32'h0);
    chk("midreset_overflow", {31'h0, overflow}, 32'h0);
`endif
    n0 = n_launch;
    send_byte(8'h3C, 1'b1);
    wait_drain("post_reset_drain");
    chk("post_reset_launches", n_launch - n0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_loopback_fifo.md
Name: uart_loopback_fifo

Overview:
- Byte buffer between the receiver's output (UartRx: data, ready, clear_ready) and the transmitter's input (UartTx: write, data, busy).
- Replaces direct ready/busy glue, so back-to-back received bytes are never lost while the transmitter is mid-frame.
- Owns both handshakes: acknowledges the receiver and paces transmitter launches from an internal circular FIFO.

Parameters:
- DATA_WIDTH, 8, byte width; matches the UART data path.
- ADDR_WIDTH, 4, FIFO pointer width; DEPTH = 2**ADDR_WIDTH (default 16 entries).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous reset, active-high.
- rx_data_i  in  DATA_WIDTH  received byte from the receiver.
- rx_ready_i  in  1  receiver holds a valid byte.
- rx_clear_ready_o  out  1  acknowledge to receiver; clears its ready flag.
- tx_data_o  out  DATA_WIDTH  byte presented to transmitter; registered.
- tx_write_o  out  1  launch request to transmitter.
- tx_busy_i  in  1  transmitter frame in progress.
- count_o  out  ADDR_WIDTH+1  occupancy (only with UART_FIFO_STATUS_EN).
- overflow_o  out  1  sticky overflow (only with UART_FIFO_STATUS_EN).

Behaviour:
- Reset (synchronous, active-high; whole block):
  - wr_ptr, rd_ptr and count go to 0.
  - rx_clear_ready_o, tx_write_o, tx_data_o and overflow_o go to 0.
  - Both FSMs go to IDLE; memory contents are don't-care.
- Reset mid-operation:
  - An in-flight transmitter frame is not aborted; the TX FSM restarts in IDLE and waits for tx_busy_i low before the next launch.
  - A byte still pending in the receiver (rx_ready_i high) after reset is captured normally.
- RX FSM, states R_IDLE and R_ACK:
  - R_IDLE, on rx_ready_i=1:
    - If not full, write rx_data_i at wr_ptr and increment wr_ptr.
    - If full, discard the byte; with the macro, set overflow_o.
    - In either case assert rx_clear_ready_o and go to R_ACK.
  - R_ACK: hold rx_clear_ready_o=1 until rx_ready_i=0, then drop it and go to R_IDLE. This guarantees exactly one push per received byte, regardless of receiver clear latency.
- TX FSM, states T_IDLE, T_LAUNCH and T_WAIT:
  - T_IDLE, when not empty and tx_busy_i=0 (same cycle):
    - Load tx_data_o from mem[rd_ptr], increment rd_ptr (pop), assert tx_write_o, go to T_LAUNCH.
    - tx_write_o rises one cycle after the condition is sampled.
  - T_LAUNCH: hold tx_write_o=1 and tx_data_o stable until tx_busy_i=1, then deassert tx_write_o and go to T_WAIT.
  - T_WAIT: on tx_busy_i=0, go to T_IDLE.
  - tx_data_o holds its value until the next launch.
- Full and empty:
  - full = (count == DEPTH); empty = (count == 0).
  - Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
  - Push and pop in the same cycle: both pointers advance and count is unchanged; this is legal even when full (a pop frees the slot in the same cycle, so the push is accepted).
- Minimum latency, empty FIFO with transmitter idle: rx_ready_i rise to tx_write_o rise is 2 cycles (push at edge 1, launch register at edge 2).
- Ordering: strict FIFO; no reordering and no duplication.

Optional Feature:
- Macro UART_FIFO_STATUS_EN.
- Defined:
  - count_o and overflow_o ports exist.
  - overflow_o is set when a byte is discarded because the FIFO is full.
  - overflow_o is cleared only by reset_i.
- Undefined:
  - Both ports are absent; count logic is trimmed to what full/empty need.
  - The discard-on-full policy is unchanged.

Decomposition:
- Shared package uart_pkg:
  - RX FSM state encoding (R_IDLE, R_ACK) and TX FSM state encoding (T_IDLE, T_LAUNCH, T_WAIT).
  - Default DATA_WIDTH constant.
- One sub-module, uart_fifo_mem: DEPTH×DATA_WIDTH register array, single write port, registered read; no reset on storage.
- Pointer, count and FSM logic stay in uart_loopback_fifo.

Test Plan:
- Single byte: rx_data_i=0xA5, rx_ready_i pulse; receiver model drops ready 2 cycles after clear → tx_write_o high at cycle +2 with tx_data_o=0xA5; exactly one push, count returns to 0 after the pop.
- Burst: 5 bytes 0x01..0x05 arrive while tx_busy_i is held high → count_o=5; on busy release, launches occur in order 0x01..0x05; each tx_write_o holds until busy rises.
- Full: tx_busy_i held high; 17 bytes pushed with DEPTH=16 → bytes 1–16 stored, 17th acknowledged and discarded, overflow_o=1 stays set; drain yields bytes 1–16 only.
- Simultaneous push and pop at count=16: on the launch cycle a new byte 0x77 arrives → accepted, count stays 16, no overflow; 0x77 is last out.
- Wrap-around: push/pop 40 bytes continuously → pointers wrap twice; output sequence equals input sequence.
- Reset mid-operation: reset_i=1 for one cycle with count=3 and tx_write_o=1 → next cycle tx_write_o=0, count_o=0, overflow_o=0; a subsequent byte 0x3C is launched normally.
